logical_rs: RTL and testbench

Reservation station directly upstream of the logical FU. It buffers dispatched logical/ALU micro-ops and captures missing source operands from the common data bus (CDB) by tag match. Each cycle it issues the oldest entry whose operands are both ready, driving the FU's type/operand inputs through registered outputs. It sits between dispatch/rename and the logical FU.

---
 rtl/ooo_pkg.sv | 17 +
 rtl/logical_rs_if.sv | 50 +++++
 rtl/rs_age_select.sv | 55 +++++
 rtl/logical_rs.sv | 168 ++++++++++++++++
 tb/tb_logical_rs.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: default tag width, logical-FU op
// code width and the logical op code encodings.
package ooo_pkg;
  localparam int TAG_W_DEF = 6;
  localparam int OP_W      = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SR   = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } logic_op_e;
endpackage

// File: rtl/logical_rs_if.sv
// Bus bundle around the logical reservation station.
//   master : dispatch / CDB / FU-control side (drives alloc_*, cdb_*, flush,
//            fu_stall; receives alloc_ready, issue_*, count)
//   slave  : the station itself
interface logical_rs_if #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 4,
  parameter int TAG_W   = ooo_pkg::TAG_W_DEF
);
  import ooo_pkg::*;
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [OP_W-1:0]       alloc_type;
  logic                  alloc_a_rdy;
  logic [XLEN-1:0]       alloc_a_val;
  logic [TAG_W-1:0]      alloc_a_tag;
  logic                  alloc_b_rdy;
  logic [XLEN-1:0]       alloc_b_val;
  logic [TAG_W-1:0]      alloc_b_tag;
  logic [TAG_W-1:0]      alloc_dest_tag;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [XLEN-1:0]       cdb_data;
  logic                  flush;
  logic                  fu_stall;
  logic                  issue_valid;
  logic [OP_W-1:0]       issue_type;
  logic [XLEN-1:0]       issue_a;
  logic [XLEN-1:0]       issue_b;
  logic [TAG_W-1:0]      issue_dest_tag;
  logic [CNT_W-1:0]      count;

  modport master (
    output alloc_valid, alloc_type, alloc_a_rdy, alloc_a_val, alloc_a_tag,
           alloc_b_rdy, alloc_b_val, alloc_b_tag, alloc_dest_tag,
           cdb_valid, cdb_tag, cdb_data, flush, fu_stall,
    input  alloc_ready, issue_valid, issue_type, issue_a, issue_b,
           issue_dest_tag, count
  );

  modport slave (
    input  alloc_valid, alloc_type, alloc_a_rdy, alloc_a_val, alloc_a_tag,
           alloc_b_rdy, alloc_b_val, alloc_b_tag, alloc_dest_tag,
           cdb_valid, cdb_tag, cdb_data, flush, fu_stall,
    output alloc_ready, issue_valid, issue_type, issue_a, issue_b,
           issue_dest_tag, count
  );
endinterface

// File: rtl/rs_age_select.sv
// Age matrix and oldest-ready picker.
//   clk, rst    : clock, sync active-high reset
//   alloc_en    : an entry is being written this edge
//   alloc_idx   : index of that entry
//   free        : registered free vector of the station
//   cand        : entries eligible to issue
//   grant       : one-hot oldest candidate
//   grant_valid : any candidate exists
module rs_age_select #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_en,
  input  logic [IDX_W-1:0]   alloc_idx,
  input  logic [ENTRIES-1:0] free,
  input  logic [ENTRIES-1:0] cand,
  output logic [ENTRIES-1:0] grant,
  output logic               grant_valid
);
  // age_q[i][j] = 1 : entry i is older than entry j
  logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;
  logic [ENTRIES-1:0]              blk;

  // New entry is younger than every live entry: row cleared (diagonal
  // included, so it stays 0), column set from the live vector.
  always_comb begin
    age_d = age_q;
    if (alloc_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (IDX_W'(i) == alloc_idx)      age_d[i][j] = 1'b0;
          else if (IDX_W'(j) == alloc_idx) age_d[i][j] = ~free[i];
        end
      end
    end
  end

  // A candidate is blocked if any older candidate exists; ages form a total
  // order over live entries so at most one candidate survives.
  always_comb begin
    blk = '0;
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        blk[i] = blk[i] | (cand[j] & age_q[j][i]);
    grant       = cand & ~blk;
    grant_valid = |cand;
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
endmodule

// File: rtl/logical_rs.sv
// Reservation station feeding the logical FU. Buffers dispatched ops,
// captures missing operands from the CDB by tag, and issues the oldest
// ready entry into registered FU-facing outputs.
//   clk, rst : clock, sync active-high reset
//   rs       : slave side of logical_rs_if (alloc_*, cdb_*, flush,
//              fu_stall in; alloc_ready, issue_*, count out)
module logical_rs
  import ooo_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 4,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  logical_rs_if.slave  rs
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic             v;
    logic [OP_W-1:0]  op;
    logic             a_rdy;
    logic [XLEN-1:0]  a_val;
    logic [TAG_W-1:0] a_tag;
    logic             b_rdy;
    logic [XLEN-1:0]  b_val;
    logic [TAG_W-1:0] b_tag;
    logic [TAG_W-1:0] dest;
  } ent_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] dest;
  } iss_t;

  ent_t [ENTRIES-1:0] ent_q, ent_d;
  ent_t               new_ent;
  iss_t               iss_q, iss_d;
  logic               iss_vld_q, iss_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ENTRIES-1:0] vld, cand, gnt;
  logic               gnt_vld, alloc_rdy, alloc_fire, issue_fire;
  logic [IDX_W-1:0]   alloc_idx, gnt_idx;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      vld[i]  = ent_q[i].v;
      cand[i] = ent_q[i].v & ent_q[i].a_rdy & ent_q[i].b_rdy;
    end
  end

  // Registered occupancy only: a slot freed by this cycle's issue is not
  // offered until next cycle.
  assign alloc_rdy  = ~&vld;
  assign alloc_fire = rs.alloc_valid & alloc_rdy & ~rs.flush;
  assign issue_fire = ~rs.fu_stall & gnt_vld & ~rs.flush;

  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!vld[i]) alloc_idx = IDX_W'(i);
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (gnt[i]) gnt_idx = gnt_idx | IDX_W'(i);
  end

  rs_age_select #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_age (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_fire),
    .alloc_idx   (alloc_idx),
    .free        (~vld),
    .cand        (cand),
    .grant       (gnt),
    .grant_valid (gnt_vld)
  );

  // Incoming op, with same-cycle CDB bypass for operands not yet ready.
  always_comb begin
    new_ent       = '0;
    new_ent.v     = 1'b1;
    new_ent.op    = rs.alloc_type;
    new_ent.a_rdy = rs.alloc_a_rdy;
    new_ent.a_val = rs.alloc_a_val;
    new_ent.a_tag = rs.alloc_a_tag;
    new_ent.b_rdy = rs.alloc_b_rdy;
    new_ent.b_val = rs.alloc_b_val;
    new_ent.b_tag = rs.alloc_b_tag;
    new_ent.dest  = rs.alloc_dest_tag;
    if (!rs.alloc_a_rdy && rs.cdb_valid && rs.cdb_tag == rs.alloc_a_tag) begin
      new_ent.a_rdy = 1'b1;
      new_ent.a_val = rs.cdb_data;
    end
    if (!rs.alloc_b_rdy && rs.cdb_valid && rs.cdb_tag == rs.alloc_b_tag) begin
      new_ent.b_rdy = 1'b1;
      new_ent.b_val = rs.cdb_data;
    end
  end

  always_comb begin
    ent_d = ent_q;
    if (rs.cdb_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!ent_q[i].a_rdy && ent_q[i].a_tag == rs.cdb_tag) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = rs.cdb_data;
        end
        if (!ent_q[i].b_rdy && ent_q[i].b_tag == rs.cdb_tag) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = rs.cdb_data;
        end
      end
    end
    if (issue_fire) ent_d[gnt_idx].v = 1'b0;
    // alloc_idx is a free slot, never the one issuing
    if (alloc_fire) ent_d[alloc_idx] = new_ent;
    if (rs.flush)
      for (int i = 0; i < ENTRIES; i++) ent_d[i].v = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < ENTRIES; i++) cnt_d = cnt_d + CNT_W'(ent_d[i].v);
  end

  always_comb begin
    iss_d     = iss_q;
    iss_vld_d = iss_vld_q;
    if (rs.flush) begin
      iss_vld_d = 1'b0;
    end else if (!rs.fu_stall) begin
      iss_vld_d = gnt_vld;
      if (gnt_vld)
        iss_d = '{op: ent_q[gnt_idx].op, a: ent_q[gnt_idx].a_val,
                  b: ent_q[gnt_idx].b_val, dest: ent_q[gnt_idx].dest};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q     <= '0;
      iss_q     <= '0;
      iss_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ent_q     <= ent_d;
      iss_q     <= iss_d;
      iss_vld_q <= iss_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rs.alloc_ready    = alloc_rdy;
  assign rs.issue_valid    = iss_vld_q;
  assign rs.issue_type     = iss_q.op;
  assign rs.issue_a        = iss_q.a;
  assign rs.issue_b        = iss_q.b;
  assign rs.issue_dest_tag = iss_q.dest;
  assign rs.count          = cnt_q;
endmodule

// File: tb/tb_logical_rs.sv
module tb_logical_rs;
  localparam int XLEN = 32, ENTRIES = 4, TAG_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logical_rs_if #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) bus ();
  logical_rs #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (bus)
  );

  // Reference model: station contents as a list ordered oldest-first.
  typedef struct {
    logic [3:0]  op;
    bit          ardy;
    logic [31:0] aval;
    logic [5:0]  atag;
    bit          brdy;
    logic [31:0] bval;
    logic [5:0]  btag;
    logic [5:0]  dest;
  } m_ent_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  dest;
  } exp_t;

  m_ent_t mq[$];
  exp_t   sb[$];
  bit     exp_iv;
  bit     done;
  int     n_cmp, n_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies one clock edge worth of rules to the model.
  function automatic void model_update();
    bit     full;
    int     sel;
    m_ent_t ne;
    if (rst || bus.flush) begin
      mq.delete();
      exp_iv = 1'b0;
      return;
    end
    full = (mq.size() >= ENTRIES);
    if (!bus.fu_stall) begin
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].ardy && mq[i].brdy) sel = i;
      if (sel >= 0) begin
        sb.push_back('{op: mq[sel].op, a: mq[sel].aval, b: mq[sel].bval, dest: mq[sel].dest});
        mq.delete(sel);
        exp_iv = 1'b1;
      end else begin
        exp_iv = 1'b0;
      end
    end
    if (bus.cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].ardy && mq[i].atag == bus.cdb_tag) begin mq[i].ardy = 1; mq[i].aval = bus.cdb_data; end
        if (!mq[i].brdy && mq[i].btag == bus.cdb_tag) begin mq[i].brdy = 1; mq[i].bval = bus.cdb_data; end
      end
    end
    if (bus.alloc_valid && !full) begin
      ne = '{op: bus.alloc_type, ardy: bus.alloc_a_rdy, aval: bus.alloc_a_val, atag: bus.alloc_a_tag,
             brdy: bus.alloc_b_rdy, bval: bus.alloc_b_val, btag: bus.alloc_b_tag, dest: bus.alloc_dest_tag};
      if (!ne.ardy && bus.cdb_valid && bus.cdb_tag == ne.atag) begin ne.ardy = 1; ne.aval = bus.cdb_data; end
      if (!ne.brdy && bus.cdb_valid && bus.cdb_tag == ne.btag) begin ne.brdy = 1; ne.bval = bus.cdb_data; end
      mq.push_back(ne);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alloc_valid = 0; bus.alloc_type = '0;
    bus.alloc_a_rdy = 0; bus.alloc_a_val = '0; bus.alloc_a_tag = '0;
    bus.alloc_b_rdy = 0; bus.alloc_b_val = '0; bus.alloc_b_tag = '0;
    bus.alloc_dest_tag = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.flush = 0; bus.fu_stall = 0;
  endtask

  task automatic set_alloc(input logic [3:0] op, input bit ar, input logic [31:0] av, input logic [5:0] at,
                           input bit br, input logic [31:0] bv, input logic [5:0] bt, input logic [5:0] d);
    bus.alloc_valid = 1; bus.alloc_type = op;
    bus.alloc_a_rdy = ar; bus.alloc_a_val = av; bus.alloc_a_tag = at;
    bus.alloc_b_rdy = br; bus.alloc_b_val = bv; bus.alloc_b_tag = bt;
    bus.alloc_dest_tag = d;
  endtask

  task automatic set_cdb(input logic [5:0] t, input logic [31:0] d);
    bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  // Monitor: compares DUT outputs against the model every cycle; each
  // predicted issue is popped from the scoreboard and then held as the
  // expected issue register contents while issue_valid stays high.
  initial begin : monitor
    exp_t cur;
    cur = '{op: '0, a: '0, b: '0, dest: '0};
    forever begin
      @(negedge clk);
      if (done) break;
      if (sb.size() > 0) cur = sb.pop_front();
      check("count", 32'(bus.count), 32'(mq.size()));
      check("alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() < ENTRIES));
      check("issue_valid", 32'(bus.issue_valid), 32'(exp_iv));
      if (exp_iv) begin
        check("issue_type", 32'(bus.issue_type), 32'(cur.op));
        check("issue_a", bus.issue_a, cur.a);
        check("issue_b", bus.issue_b, cur.b);
        check("issue_dest", 32'(bus.issue_dest_tag), 32'(cur.dest));
      end
    end
  end

  initial begin
    done = 0; n_cmp = 0; n_err = 0; exp_iv = 0;
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_type", 32'(bus.issue_type), 0);
    check("rst_a", bus.issue_a, 0);
    check("rst_b", bus.issue_b, 0);
    check("rst_dest", 32'(bus.issue_dest_tag), 0);

    // ready alloc
    set_alloc(4'b0100, 1, 32'hF0F0_0000, 0, 1, 32'h0FF0_0000, 0, 5); tick();
    idle(); tick(); tick();
    // wakeup three cycles after dispatch
    set_alloc(4'b0000, 0, 0, 9, 1, 3, 0, 6); tick();
    idle(); tick(); tick();
    set_cdb(9, 32'h1234); tick();
    idle(); tick(); tick();
    // alloc-time bypass
    set_alloc(4'b0110, 0, 0, 7, 1, 5, 0, 7); set_cdb(7, 32'hAA); tick();
    idle(); tick(); tick();
    // age order, plus an extra request held while full
    for (int k = 0; k < 4; k++) begin
      set_alloc(4'b0111, 0, 0, 1, 1, 32'(k), 0, 6'(10 + k)); tick();
    end
    set_alloc(4'b0001, 1, 32'h55, 0, 1, 32'h66, 0, 14); tick();
    set_cdb(1, 32'hBEEF); tick();
    bus.cdb_valid = 0; tick();
    idle(); repeat (6) tick();
    // stall with ready entries
    for (int k = 0; k < 3; k++) begin
      set_alloc(4'b0010, 1, 32'(100 + k), 0, 1, 32'(200 + k), 0, 6'(20 + k)); tick();
    end
    idle(); bus.fu_stall = 1; repeat (3) tick();
    bus.fu_stall = 0; repeat (4) tick();
    // flush with full station and a live issue
    set_alloc(4'b0011, 1, 1, 0, 1, 2, 0, 30); tick();
    idle(); tick();
    bus.fu_stall = 1;
    for (int k = 0; k < 4; k++) begin
      set_alloc(4'b0101, 1, 32'(k), 0, 1, 32'(k), 0, 6'(31 + k)); tick();
    end
    set_alloc(4'b0101, 1, 9, 0, 1, 9, 0, 40); bus.flush = 1; tick();
    check("flush_count", 32'(bus.count), 0);
    check("flush_iv", 32'(bus.issue_valid), 0);
    idle(); tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        set_alloc(4'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
      if ($urandom_range(0, 99) < 40) set_cdb(6'($urandom_range(0, 7)), $urandom);
      bus.fu_stall = ($urandom_range(0, 99) < 20);
      bus.flush    = ($urandom_range(0, 99) < 2);
      rst          = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 0;

    // drain: broadcast every tag so nothing is left waiting
    for (int t = 0; t < 64; t++) begin
      idle(); set_cdb(6'(t), 32'(t * 3)); tick();
    end
    idle(); repeat (6) tick();
    check("drain_count", 32'(bus.count), 0);

    done = 1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
